// File: rtl/rc4_pkg.sv
// Shared RC4 definitions for the S-init, key-schedule, keystream and checker blocks.
package rc4_pkg;
   localparam int S_AW    = 8;
   localparam int MSG_AW  = 5;
   localparam int MSG_LEN = 32;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_SI,
      ST_WT_SI,
      ST_RD_SJ,
      ST_WT_SJ,
      ST_WR_I,
      ST_WR_J,
      ST_RD_F,
      ST_WT_F,
      ST_PRESENT,
      ST_WAIT_ACK,
      ST_DONE
   } rc4_state_t;
endpackage

// File: rtl/decrypt_char_stream.sv
// RC4 keystream/decrypt engine: produces one plaintext byte per checker handshake.
//
// state       | meaning
// ------------+---------------------------------------------------
// ST_IDLE     | waiting for key scheduling to finish (start)
// ST_RD_SI    | i <= i+1, read s[i+1]
// ST_WT_SI    | capture si
// ST_RD_SJ    | j <= j+si, read s[j+si]
// ST_WT_SJ    | capture sj
// ST_WR_I     | s[i] <= sj
// ST_WR_J     | s[j] <= si
// ST_RD_F     | read s[si+sj]
// ST_WT_F     | char_out <= keystream ^ encrypted byte
// ST_PRESENT  | write decrypted RAM, raise new_char
// ST_WAIT_ACK | hold new_char until a compared_char rising edge
// ST_DONE     | whole message produced, wait for start_over
module decrypt_char_stream
   import rc4_pkg::*;
#(
   parameter int MSG_LEN = rc4_pkg::MSG_LEN
) (
   input  logic              clok,
   input  logic              resetm,
   input  logic              start,
   input  logic              start_over,
   output logic [S_AW-1:0]   s_addr,
   output logic [7:0]        s_wdata,
   output logic              s_wren,
   input  logic [7:0]        s_rdata,
   output logic [MSG_AW-1:0] enc_addr,
   input  logic [7:0]        enc_rdata,
   output logic [MSG_AW-1:0] dec_addr,
   output logic [7:0]        dec_wdata,
   output logic              dec_wren,
   output logic [7:0]        char_out,
   output logic              new_char,
   input  logic              compared_char,
   output logic [5:0]        char_count,
   output logic              done
);

   localparam logic [5:0] LP_LEN = 6'(MSG_LEN);

   rc4_state_t r_state, w_next;

   logic [7:0] r_i, r_j, r_si, r_sj, r_char;
   logic [5:0] r_k;
   logic       r_ack_q, r_new, r_done;
   logic       w_ack_rise;
   logic [5:0] w_k_inc;

   assign w_ack_rise = compared_char & ~r_ack_q;
   assign w_k_inc    = r_k + 6'd1;

   always_ff @(posedge clok or posedge resetm) begin
      if (resetm) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      s_addr   = '0;
      s_wdata  = '0;
      s_wren   = 1'b0;
      dec_wren = 1'b0;
      case (r_state)
         ST_IDLE:     if (start) w_next = ST_RD_SI;
         ST_RD_SI: begin
            s_addr = r_i + 8'd1;
            w_next = ST_WT_SI;
         end
         ST_WT_SI:    w_next = ST_RD_SJ;
         ST_RD_SJ: begin
            s_addr = r_j + r_si;
            w_next = ST_WT_SJ;
         end
         ST_WT_SJ:    w_next = ST_WR_I;
         ST_WR_I: begin
            s_addr  = r_i;
            s_wdata = r_sj;
            s_wren  = 1'b1;
            w_next  = ST_WR_J;
         end
         ST_WR_J: begin
            s_addr  = r_j;
            s_wdata = r_si;
            s_wren  = 1'b1;
            w_next  = ST_RD_F;
         end
         ST_RD_F: begin
            s_addr = r_si + r_sj;
            w_next = ST_WT_F;
         end
         ST_WT_F:     w_next = ST_PRESENT;
         ST_PRESENT: begin
            dec_wren = 1'b1;
            w_next   = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: if (w_ack_rise) w_next = (w_k_inc == LP_LEN) ? ST_DONE : ST_RD_SI;
         ST_DONE:     w_next = ST_DONE;
         default:     w_next = ST_IDLE;
      endcase
      // abort must also kill a write already decoded for this cycle
      if (start_over) begin
         w_next   = ST_IDLE;
         s_wren   = 1'b0;
         dec_wren = 1'b0;
      end
   end

   always_ff @(posedge clok or posedge resetm) begin
      if (resetm) begin
         r_i     <= '0;
         r_j     <= '0;
         r_k     <= '0;
         r_si    <= '0;
         r_sj    <= '0;
         r_char  <= '0;
         r_new   <= 1'b0;
         r_done  <= 1'b0;
         r_ack_q <= 1'b0;
      end else begin
         r_ack_q <= compared_char;
         if (start_over) begin
            r_i    <= '0;
            r_j    <= '0;
            r_k    <= '0;
            r_new  <= 1'b0;
            r_done <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: if (start) begin
                  r_i <= '0;
                  r_j <= '0;
                  r_k <= '0;
               end
               ST_RD_SI:   r_i    <= r_i + 8'd1;
               ST_WT_SI:   r_si   <= s_rdata;
               ST_RD_SJ:   r_j    <= r_j + r_si;
               ST_WT_SJ:   r_sj   <= s_rdata;
               ST_WT_F:    r_char <= s_rdata ^ enc_rdata;
               ST_PRESENT: r_new  <= 1'b1;
               ST_WAIT_ACK: if (w_ack_rise) begin
                  r_new <= 1'b0;
                  r_k   <= w_k_inc;
                  if (w_k_inc == LP_LEN) r_done <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // ROM address held at k so enc_rdata is stable by WT_F
   assign enc_addr   = r_k[MSG_AW-1:0];
   assign dec_addr   = r_k[MSG_AW-1:0];
   assign dec_wdata  = r_char;
   assign char_out   = r_char;
   assign new_char   = r_new;
   assign char_count = r_k;
   assign done       = r_done;

endmodule

// File: doc/decrypt_char_stream.md
# decrypt_char_stream

RC4 keystream/decrypt engine (loop 3) that produces one decrypted character at a time for the downstream character checker. It runs after S-array init (loop 1) and key scheduling (loop 2), reads the shared S RAM and the encrypted-message ROM, and writes each plaintext byte to the decrypted RAM. It presents each byte on `char_out` with a `new_char` flag and a `char_count` index. It waits for the checker's `compared_char` before advancing, and abandons the pass on `start_over`.

## Interface
- `MSG_LEN`, 32: message length in bytes; `char_count` reaching `MSG_LEN` means the string is finished.
- `clok` in 1: single clock, rising edge.
- `resetm` in 1: reset, asynchronous, active-high.
- `start` in 1: loop 2 done; sampled only in IDLE.
- `start_over` in 1: abort current pass (new key); highest priority after reset.
- `s_addr` out 8: S RAM address.
- `s_wdata` out 8: S RAM write data.
- `s_wren` out 1: S RAM write enable.
- `s_rdata` in 8: S RAM read data, valid 1 cycle after the address.
- `enc_addr` out 5: encrypted ROM address.
- `enc_rdata` in 8: ROM data, valid 1 cycle after the address.
- `dec_addr` out 5: decrypted RAM address.
- `dec_wdata` out 8: decrypted RAM write data.
- `dec_wren` out 1: decrypted RAM write enable.
- `char_out` out 8: current decrypted byte.
- `new_char` out 1: `char_out` valid; held until acknowledged.
- `compared_char` in 1: checker acknowledge; level, may stay high.
- `char_count` out 6: index k of the current or next byte.
- `done` out 1: all `MSG_LEN` bytes produced; sticky until `start_over` or reset.

## Operation
- Registers:
  - `i`, `j`: 8 bits, wrap mod 256.
  - `k`: 6 bits.
  - `si`, `sj`: 8 bits, captured S values.
  - `ack_q`: previous `compared_char`.
- Per byte k: i=i+1; j=j+s[i]; swap s[i],s[j]; f=s[(s[i]+s[j]) mod 256]; out = f XOR enc[k].
  - Swap uses the captured pre-swap values.
  - f address = si+sj, 8-bit truncated sum of the captured values.
- States and transitions:
  - IDLE: on `start`, clear i, j, k; go to RD_SI.
  - RD_SI: s_addr=i+1, i<=i+1, enc_addr=k.
  - WT_SI: si<=s_rdata.
  - RD_SJ: j<=j+si, s_addr=j+si.
  - WT_SJ: sj<=s_rdata.
  - WR_I: s_addr=i, s_wdata=sj, s_wren=1.
  - WR_J: s_addr=j, s_wdata=si, s_wren=1.
  - RD_F: s_addr=si+sj.
  - WT_F: char_out<=s_rdata^enc_rdata.
    - enc_rdata has been stable since RD_SI; ROM address is held at k.
  - PRESENT: dec_addr=k, dec_wdata=char_out, dec_wren=1 (one cycle), new_char<=1.
  - WAIT_ACK: hold `new_char`=1 until a rising edge of `compared_char` (compared_char & ~ack_q); then new_char<=0 and k<=k+1.
    - If k+1==MSG_LEN: go to DONE_ST.
    - Otherwise go to RD_SI.
  - DONE_ST: done=1; `char_count`=MSG_LEN; stay until `start_over`.
- `start_over` high in any state: next state IDLE; clear new_char, done, i, j, k; deassert all write enables.
  - S RAM content is not restored; loops 1/2 re-initialise it.
- `start` and `start_over` high together in IDLE: `start_over` wins and the block stays in IDLE.
- Write enables are never high outside WR_I, WR_J and PRESENT.

## Timing
- Reset values: all outputs 0; state IDLE; i=j=k=0; ack_q=0.
- Leaving IDLE (or acknowledge in WAIT_ACK) to `new_char` high: 9 cycles.
- Acknowledge edge to `new_char` low: 1 cycle.
- `char_count` changes only on the acknowledge cycle; it is stable while `new_char`=1.
- An acknowledge level already high when entering WAIT_ACK is not accepted; a fresh rising edge is required.
- Reset mid-operation: immediate asynchronous return to reset values; a pending S write is dropped.

## Structure
- Shared package `rc4_pkg`:
  - state enum type.
  - `MSG_LEN`.
  - `S_AW`=8, `MSG_AW`=5 width constants (also used by loops 1/2 and the checker).
- No RTL sub-module.
- Bench uses a behavioural 256x8 synchronous RAM model `s_mem_model` and a 32x8 ROM model.

## Test plan
- Identity S (s[x]=x), enc[0]=0x41, start pulse.
  - Expect char_out=0x43 (0x41^0x02), new_char after 9 cycles, char_count=0, dec RAM[0]=0x43.
- Continue with ack pulse, enc[1]=0x60.
  - Expect s[2]=3, s[3]=2, char_out=0x65 (0x60^0x05), char_count=1.
- Hold compared_char high continuously.
  - Expect exactly one byte advance per rising edge, never free-running.
- Full 32-byte run against a software RC4 model with a 3-byte key.
  - Expect every char_out and dec RAM byte to match, then done=1 and char_count=32.
- Assert start_over during WR_I, and again during WAIT_ACK.
  - Expect IDLE next cycle, new_char=0, done=0, char_count=0, no further writes.
- Assert resetm mid-character.
  - Expect all outputs 0 asynchronously.
  - Expect a restart with start to reproduce the first byte correctly after S is re-initialised.
